// File: rtl/functions_pkg.sv
// Shared elaboration-time helper functions.
package functions_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pool_ctrl_pkg.sv
// Types and widths shared by the pooling frame sequencer, its scan counter and its port bundle.
package pool_ctrl_pkg;
  import functions_pkg::*;

  localparam int FRAME_H_MAX_DEF   = 224;
  localparam int FRAME_W_MAX_DEF   = 224;
  localparam int STRIDE_MAX_DEF    = 4;
  localparam int DRAIN_TIMEOUT_DEF = 1024;

  localparam int HB = clog2(FRAME_H_MAX_DEF) + 1;
  localparam int WB = clog2(FRAME_W_MAX_DEF) + 1;
  localparam int SB = clog2(STRIDE_MAX_DEF) + 1;
  localparam int AW = clog2(FRAME_H_MAX_DEF * FRAME_W_MAX_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pool_frame_ctrl_if.sv
// Port bundle between the frame sequencer (master) and scheduler / buffers / max_pool (slave).
interface pool_frame_ctrl_if;

  logic                         start;
  logic [pool_ctrl_pkg::HB-1:0] cfg_h;
  logic [pool_ctrl_pkg::WB-1:0] cfg_w;
  logic [pool_ctrl_pkg::SB-1:0] cfg_stride;
  logic                         feed_en;
  logic                         busy;
  logic                         done;
  logic                         cfg_err;
  logic                         to_err;
  logic                         rd_en;
  logic [pool_ctrl_pkg::AW-1:0] rd_addr;
  logic [pool_ctrl_pkg::HB-1:0] pool_frame_h;
  logic [pool_ctrl_pkg::WB-1:0] pool_frame_w;
  logic [pool_ctrl_pkg::SB-1:0] pool_stride;
  logic                         pool_frame_start;
  logic                         pool_din_vld;
  logic                         pool_dout_vld;
  logic                         wr_en;
  logic [pool_ctrl_pkg::AW-1:0] wr_addr;
  logic [pool_ctrl_pkg::AW-1:0] out_cnt;

  modport master (
    input  start, cfg_h, cfg_w, cfg_stride, feed_en, pool_dout_vld,
    output busy, done, cfg_err, to_err, rd_en, rd_addr,
           pool_frame_h, pool_frame_w, pool_stride, pool_frame_start, pool_din_vld,
           wr_en, wr_addr, out_cnt
  );

  modport slave (
    output start, cfg_h, cfg_w, cfg_stride, feed_en, pool_dout_vld,
    input  busy, done, cfg_err, to_err, rd_en, rd_addr,
           pool_frame_h, pool_frame_w, pool_stride, pool_frame_start, pool_din_vld,
           wr_en, wr_addr, out_cnt
  );

endinterface

// File: rtl/pool_scan_cnt.sv
// Row-major pixel scan: row/column position, stride phases and linear read address.
// Advances one pixel per adv; parks on the last pixel until the next clr.
module pool_scan_cnt
  import pool_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          adv,
  input  logic [HB-1:0] frame_h,
  input  logic [WB-1:0] frame_w,
  input  logic [SB-1:0] stride,
  output logic [AW-1:0] addr,
  output logic          last_pixel,
  output logic          out_hit
);

  logic [HB-1:0] row_q, row_d;
  logic [WB-1:0] col_q, col_d;
  logic [SB-1:0] row_ph_q, row_ph_d;
  logic [SB-1:0] col_ph_q, col_ph_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          col_wrap;

  always_comb begin
    col_wrap   = (col_q == frame_w - WB'(1));
    last_pixel = col_wrap && (row_q == frame_h - HB'(1));
    // A pooling window is anchored wherever both phases are zero.
    out_hit    = (row_ph_q == '0) && (col_ph_q == '0);
    row_d      = row_q;
    col_d      = col_q;
    row_ph_d   = row_ph_q;
    col_ph_d   = col_ph_q;
    addr_d     = addr_q;
    if (clr) begin
      row_d    = '0;
      col_d    = '0;
      row_ph_d = '0;
      col_ph_d = '0;
      addr_d   = '0;
    end else if (adv && !last_pixel) begin
      addr_d = addr_q + AW'(1);
      if (col_wrap) begin
        col_d    = '0;
        col_ph_d = '0;
        row_d    = row_q + HB'(1);
        row_ph_d = (row_ph_q == stride - SB'(1)) ? '0 : row_ph_q + SB'(1);
      end else begin
        col_d    = col_q + WB'(1);
        col_ph_d = (col_ph_q == stride - SB'(1)) ? '0 : col_ph_q + SB'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q    <= '0;
      col_q    <= '0;
      row_ph_q <= '0;
      col_ph_q <= '0;
      addr_q   <= '0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      row_ph_q <= row_ph_d;
      col_ph_q <= col_ph_d;
      addr_q   <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/pool_frame_ctrl.sv
// Frame sequencer for max_pool: latches config, feeds pixels, counts and addresses pooled writes.
// Reads are issued combinationally from the FEED state and feed_en; writes follow pool_dout_vld directly.
module pool_frame_ctrl
  import pool_ctrl_pkg::*;
#(
  parameter int FRAME_H_MAX   = FRAME_H_MAX_DEF,
  parameter int FRAME_W_MAX   = FRAME_W_MAX_DEF,
  parameter int STRIDE_MAX    = STRIDE_MAX_DEF,
  parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  pool_frame_ctrl_if.master bus
);

  localparam int TW = functions_pkg::clog2(DRAIN_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [HB-1:0] h_q, h_d;
  logic [WB-1:0] w_q, w_d;
  logic [SB-1:0] s_q, s_d;
  logic [AW-1:0] exp_q, exp_d;
  logic [AW-1:0] out_cnt_q, out_cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          cfg_err_q, cfg_err_d;
  logic          to_err_q, to_err_d;
  logic          din_vld_q, din_vld_d;
  logic          fstart_q, fstart_d;

  logic          cfg_ok;
  logic          accept;
  logic          busy;
  logic          rd_en;
  logic          wr_en;
  logic          last_pixel;
  logic          out_hit;
  logic [AW-1:0] scan_addr;

  pool_scan_cnt u_scan (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (accept),
    .adv        (rd_en),
    .frame_h    (h_q),
    .frame_w    (w_q),
    .stride     (s_q),
    .addr       (scan_addr),
    .last_pixel (last_pixel),
    .out_hit    (out_hit)
  );

  always_comb begin
    cfg_ok = (bus.cfg_h != '0) && (int'(bus.cfg_h) <= FRAME_H_MAX) &&
             (bus.cfg_w != '0) && (int'(bus.cfg_w) <= FRAME_W_MAX) &&
             (bus.cfg_stride != '0) && (int'(bus.cfg_stride) <= STRIDE_MAX);
    busy   = (state_q == FEED) || (state_q == DRAIN);
    accept = (state_q == IDLE) && bus.start && cfg_ok;
    rd_en  = (state_q == FEED) && bus.feed_en;
    // exp_q only counts windows already read, so early or surplus results are dropped.
    wr_en  = busy && bus.pool_dout_vld && (out_cnt_q < exp_q);

    state_d   = state_q;
    h_d       = h_q;
    w_d       = w_q;
    s_d       = s_q;
    exp_d     = (rd_en && out_hit) ? exp_q + AW'(1) : exp_q;
    out_cnt_d = wr_en ? out_cnt_q + AW'(1) : out_cnt_q;
    idle_d    = '0;
    cfg_err_d = 1'b0;
    to_err_d  = to_err_q;
    din_vld_d = rd_en;
    fstart_d  = rd_en && (scan_addr == '0);

    case (state_q)
      IDLE: begin
        cfg_err_d = bus.start && !cfg_ok;
        if (accept) begin
          state_d   = FEED;
          h_d       = bus.cfg_h;
          w_d       = bus.cfg_w;
          s_d       = bus.cfg_stride;
          exp_d     = '0;
          out_cnt_d = '0;
          to_err_d  = 1'b0;
        end
      end
      FEED: begin
        if (rd_en && last_pixel) state_d = DRAIN;
      end
      DRAIN: begin
        // Completion is judged on the post-write count so done lands the cycle after the final write.
        if (out_cnt_d == exp_q) begin
          state_d = DONE;
        end else if (bus.pool_dout_vld) begin
          idle_d = '0;
        end else if (idle_q == TW'(DRAIN_TIMEOUT - 1)) begin
          state_d  = IDLE;
          to_err_d = 1'b1;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      h_q       <= '0;
      w_q       <= '0;
      s_q       <= '0;
      exp_q     <= '0;
      out_cnt_q <= '0;
      idle_q    <= '0;
      cfg_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      din_vld_q <= 1'b0;
      fstart_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      w_q       <= w_d;
      s_q       <= s_d;
      exp_q     <= exp_d;
      out_cnt_q <= out_cnt_d;
      idle_q    <= idle_d;
      cfg_err_q <= cfg_err_d;
      to_err_q  <= to_err_d;
      din_vld_q <= din_vld_d;
      fstart_q  <= fstart_d;
    end
  end

  assign bus.busy             = busy;
  assign bus.done             = (state_q == DONE);
  assign bus.cfg_err          = cfg_err_q;
  assign bus.to_err           = to_err_q;
  assign bus.rd_en            = rd_en;
  assign bus.rd_addr          = scan_addr;
  assign bus.pool_frame_h     = h_q;
  assign bus.pool_frame_w     = w_q;
  assign bus.pool_stride      = s_q;
  assign bus.pool_frame_start = fstart_q;
  assign bus.pool_din_vld     = din_vld_q;
  assign bus.wr_en            = wr_en;
  assign bus.wr_addr          = out_cnt_q;
  assign bus.out_cnt          = out_cnt_q;

endmodule

// File: tb/tb_pool_frame_ctrl.sv
// Directed + randomized bench for pool_frame_ctrl against a pixel/result counting model.
module tb_pool_frame_ctrl;
  import pool_ctrl_pkg::*;

  localparam int TMO = 16;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  pool_frame_ctrl_if ifc ();

  pool_frame_ctrl #(
    .FRAME_H_MAX   (224),
    .FRAME_W_MAX   (224),
    .STRIDE_MAX    (4),
    .DRAIN_TIMEOUT (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, ifc.busy, 0);
    chk({tag, "_done"}, ifc.done, 0);
    chk({tag, "_cfg_err"}, ifc.cfg_err, 0);
    chk({tag, "_to_err"}, ifc.to_err, 0);
    chk({tag, "_rd_en"}, ifc.rd_en, 0);
    chk({tag, "_rd_addr"}, ifc.rd_addr, 0);
    chk({tag, "_fstart"}, ifc.pool_frame_start, 0);
    chk({tag, "_din_vld"}, ifc.pool_din_vld, 0);
    chk({tag, "_wr_en"}, ifc.wr_en, 0);
    chk({tag, "_wr_addr"}, ifc.wr_addr, 0);
    chk({tag, "_out_cnt"}, ifc.out_cnt, 0);
    chk({tag, "_frame_h"}, ifc.pool_frame_h, 0);
    chk({tag, "_frame_w"}, ifc.pool_frame_w, 0);
    chk({tag, "_stride"}, ifc.pool_stride, 0);
  endtask

  task automatic idle_cycle(input bit exp_to);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.pool_dout_vld = 1'b0;
    ifc.feed_en = 1'b1;
    #1;
    chk("idle_busy", ifc.busy, 0);
    chk("idle_done", ifc.done, 0);
    chk("idle_rd_en", ifc.rd_en, 0);
    chk("idle_to_err", ifc.to_err, 32'(exp_to));
  endtask

  task automatic bad_cfg(input int h, input int w, input int s, input bit exp_to);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.cfg_h = HB'(h);
    ifc.cfg_w = WB'(w);
    ifc.cfg_stride = SB'(s);
    ifc.feed_en = 1'b1;
    ifc.pool_dout_vld = 1'b0;
    #1;
    chk("bad_rd_en0", ifc.rd_en, 0);
    @(negedge clk);
    ifc.start = 1'b0;
    #1;
    chk("bad_cfg_err", ifc.cfg_err, 1);
    chk("bad_busy", ifc.busy, 0);
    chk("bad_rd_en1", ifc.rd_en, 0);
    chk("bad_to_err", ifc.to_err, 32'(exp_to));
    @(negedge clk);
    #1;
    chk("bad_cfg_err_pulse", ifc.cfg_err, 0);
    chk("bad_rd_en2", ifc.rd_en, 0);
  endtask

  // fmode: 0 feed_en high, 1 toggling, 2 random. late_last holds the final result
  // until the drain idle run is one short of the timeout.
  task automatic run_frame(input int h, input int w, input int s, input int fmode,
                           input int nres, input bit late_last);
    int e, hw, reads, writes, hits, sent, idle, ph, limit, c;
    bit fe, dv, exp_rd, exp_wr, prev_rd, prev_first, fin;
    e = ((h + s - 1) / s) * ((w + s - 1) / s);
    hw = h * w;
    limit = hw * 4 + 100;
    reads = 0; writes = 0; hits = 0; sent = 0; idle = 0; ph = 0;
    prev_rd = 0; prev_first = 0; fin = 0;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.cfg_h = HB'(h);
    ifc.cfg_w = WB'(w);
    ifc.cfg_stride = SB'(s);
    ifc.feed_en = 1'($urandom_range(0, 1));
    ifc.pool_dout_vld = 1'($urandom_range(0, 1));
    #1;
    chk("start_busy", ifc.busy, 0);
    chk("start_wr_en", ifc.wr_en, 0);
    chk("start_rd_en", ifc.rd_en, 0);
    for (c = 1; c <= limit && !fin; c++) begin
      @(negedge clk);
      ifc.start = (ph < 2) && ($urandom_range(0, 5) == 0);
      ifc.cfg_h = HB'($urandom_range(0, 10));
      ifc.cfg_w = WB'($urandom_range(0, 10));
      ifc.cfg_stride = SB'($urandom_range(0, 5));
      fe = (fmode == 0) ? 1'b1 : (fmode == 1) ? c[0] : 1'($urandom_range(0, 1));
      dv = 1'b0;
      if (ph < 2 && sent < nres && sent < hits) begin
        if (sent == nres - 1) begin
          if (ph == 1)
            dv = late_last ? (idle == TMO - 1) : (($urandom_range(0, 2) != 0) || idle >= 8);
        end else begin
          dv = ($urandom_range(0, 2) != 0) || (ph == 1 && idle >= 8);
        end
      end else if (ph >= 2) begin
        dv = 1'($urandom_range(0, 1));
      end
      ifc.feed_en = fe;
      ifc.pool_dout_vld = dv;
      #1;
      exp_rd = (ph == 0) && fe;
      exp_wr = dv && (ph < 2) && (writes < e);
      chk("busy", ifc.busy, 32'(ph < 2));
      chk("done", ifc.done, 32'(ph == 2));
      chk("to_err", ifc.to_err, 32'(ph == 3));
      chk("cfg_err", ifc.cfg_err, 0);
      chk("rd_en", ifc.rd_en, 32'(exp_rd));
      chk("din_vld", ifc.pool_din_vld, 32'(prev_rd));
      chk("frame_start", ifc.pool_frame_start, 32'(prev_first));
      chk("wr_en", ifc.wr_en, 32'(exp_wr));
      chk("out_cnt", ifc.out_cnt, writes);
      chk("cfg_h_out", ifc.pool_frame_h, h);
      chk("cfg_w_out", ifc.pool_frame_w, w);
      chk("cfg_s_out", ifc.pool_stride, s);
      if (ph == 0) chk("rd_addr", ifc.rd_addr, reads);
      if (exp_wr) chk("wr_addr", ifc.wr_addr, writes);
      if (ph >= 2) begin
        fin = 1'b1;
      end else begin
        prev_rd = exp_rd;
        prev_first = exp_rd && (reads == 0);
        if (exp_rd) begin
          if (((reads / w) % s == 0) && ((reads % w) % s == 0)) hits++;
          reads++;
        end
        if (dv) sent++;
        if (exp_wr) writes++;
        if (ph == 1) begin
          if (writes == e) ph = 2;
          else if (dv) idle = 0;
          else begin
            idle++;
            if (idle == TMO) ph = 3;
          end
        end else if (reads == hw) begin
          ph = 1;
        end
      end
    end
    chk("frame_finished", 32'(fin), 1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    ifc.start = 1'b0;
    ifc.cfg_h = '0;
    ifc.cfg_w = '0;
    ifc.cfg_stride = '0;
    ifc.feed_en = 1'b0;
    ifc.pool_dout_vld = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    reset_n = 1'b1;

    run_frame(4, 4, 1, 0, 16, 0);
    idle_cycle(0);
    chk("f1_out_cnt", ifc.out_cnt, 16);

    run_frame(5, 5, 2, 0, 9, 0);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.pool_dout_vld = 1'b1;
    #1;
    chk("extra_wr_en", ifc.wr_en, 0);
    chk("extra_out_cnt", ifc.out_cnt, 9);

    bad_cfg(4, 4, 0, 0);
    bad_cfg(4, 225, 1, 0);
    bad_cfg(0, 4, 1, 0);
    bad_cfg(225, 4, 1, 0);
    bad_cfg(4, 4, 5, 0);
    chk("hold_h", ifc.pool_frame_h, 5);
    chk("hold_s", ifc.pool_stride, 2);

    run_frame(4, 4, 2, 1, 4, 0);
    idle_cycle(0);

    run_frame(4, 4, 2, 0, 3, 0);
    repeat (3) idle_cycle(1);
    chk("to_out_cnt", ifc.out_cnt, 3);
    bad_cfg(2, 2, 0, 1);
    run_frame(3, 7, 3, 2, 3, 1);
    idle_cycle(0);

    @(negedge clk);
    ifc.start = 1'b1;
    ifc.cfg_h = HB'(4);
    ifc.cfg_w = WB'(4);
    ifc.cfg_stride = SB'(1);
    ifc.feed_en = 1'b1;
    ifc.pool_dout_vld = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      ifc.start = (i == 4);
      if (i == 4) begin
        ifc.cfg_h = HB'(2);
        ifc.cfg_w = WB'(2);
      end
      #1;
      chk("rst_pre_rd_addr", ifc.rd_addr, i - 1);
      chk("rst_pre_busy", ifc.busy, 1);
    end
    @(negedge clk);
    reset_n = 1'b0;
    ifc.start = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) idle_cycle(0);
    run_frame(3, 3, 1, 2, 9, 0);

    for (int k = 0; k < 6; k++) begin
      int h, w, s;
      h = $urandom_range(1, 9);
      w = $urandom_range(1, 9);
      s = $urandom_range(1, 4);
      run_frame(h, w, s, 2, ((h + s - 1) / s) * ((w + s - 1) / s), 1'($urandom_range(0, 1)));
    end
    run_frame(1, 1, 4, 0, 1, 0);
    run_frame(224, 1, 4, 0, 56, 0);
    idle_cycle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
